// File: rtl/task_sequencer.sv
// task_sequencer: polls a shared-memory mailbox for task requests, validates
// the requested task number against ENABLED_MASK, hands accepted tasks to the
// task engine and reports completion back through TV_OUT_READY.
// Optional feature: define TASK_SEQ_TIMEOUT_EN to add a BUSY watchdog that
// sets err_timeout and forces completion after TIMEOUT_CYCLES.
module task_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 17,
  parameter logic [15:0] ENABLED_MASK   = 16'h046E,
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  task_start,
  output logic [3:0]            task_id,
  input  logic                  task_done,
  output logic                  busy,
  output logic                  err_unsupported,
  output logic                  err_timeout
);

  localparam logic [ADDR_WIDTH-1:0] A_PL_READY      = ADDR_WIDTH'(32'h0001_0000);
  localparam logic [ADDR_WIDTH-1:0] A_ENABLED_TASKS = ADDR_WIDTH'(32'h0001_0004);
  localparam logic [ADDR_WIDTH-1:0] A_CURRENT_TASK  = ADDR_WIDTH'(32'h0001_0008);
  localparam logic [ADDR_WIDTH-1:0] A_TV_IN_READY   = ADDR_WIDTH'(32'h0001_000C);
  localparam logic [ADDR_WIDTH-1:0] A_TV_OUT_READY  = ADDR_WIDTH'(32'h0001_0010);

  localparam int unsigned POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  if (POLL_INTERVAL == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("task_sequencer: POLL_INTERVAL and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [3:0] {
    INIT_EN, INIT_RDY, POLL_WAIT, RD_FLAG, CHK_FLAG, RD_TASK,
    CHK_TASK, CLR_FLAG, START, BUSY, DONE_WR
  } state_t;

  state_t              state, state_nxt;
  // Each init state spends two cycles: INIT_EN idles once after reset (the
  // registered bus is held at zero) then writes; INIT_RDY issues two writes.
  logic                init_step, init_step_nxt;
  logic [POLL_W-1:0]   poll_cnt;
  logic                poll_done;
  logic [3:0]          task_num;
  logic                task_ok;
  logic                wd_expired;

  logic                  mem_en_d;
  logic [3:0]            mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [31:0]           mem_wdata_d;
  logic                  task_start_d;
  logic                  busy_d;

  // A task word is valid only as 1..15 with zero upper bits and its mask bit set.
  function automatic logic task_accepted(input logic [31:0] word);
    task_accepted = (word[31:4] == 28'd0) && (word[3:0] != 4'd0) &&
                    ENABLED_MASK[word[3:0]];
  endfunction

  assign poll_done = (poll_cnt == POLL_W'(POLL_INTERVAL - 1));

  // State register plus poll counter and captured task decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= INIT_EN;
      init_step       <= 1'b0;
      poll_cnt        <= '0;
      task_num        <= 4'd0;
      task_ok         <= 1'b0;
      err_unsupported <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_step <= init_step_nxt;
      poll_cnt  <= (state == POLL_WAIT) ? poll_cnt + 1'b1 : '0;
      if (state == CHK_TASK) begin
        task_num <= mem_rdata[3:0];
        task_ok  <= task_accepted(mem_rdata);
        if (!task_accepted(mem_rdata)) begin
          err_unsupported <= 1'b1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    init_step_nxt = 1'b0;
    case (state)
      INIT_EN: begin
        if (!init_step) init_step_nxt = 1'b1;
        else            state_nxt     = INIT_RDY;
      end
      INIT_RDY: begin
        if (!init_step) init_step_nxt = 1'b1;
        else            state_nxt     = POLL_WAIT;
      end
      POLL_WAIT: if (poll_done) state_nxt = RD_FLAG;
      RD_FLAG:   state_nxt = CHK_FLAG;
      CHK_FLAG:  state_nxt = (mem_rdata == 32'h1) ? RD_TASK : POLL_WAIT;
      RD_TASK:   state_nxt = CHK_TASK;
      CHK_TASK:  state_nxt = CLR_FLAG;
      CLR_FLAG:  state_nxt = task_ok ? START : DONE_WR;
      START:     state_nxt = BUSY;
      BUSY:      if (task_done || wd_expired) state_nxt = DONE_WR;
      DONE_WR:   state_nxt = POLL_WAIT;
      default:   state_nxt = INIT_EN;
    endcase
  end

  // Output decode from the upcoming state so every output is a plain register
  always_comb begin
    mem_en_d     = 1'b0;
    mem_we_d     = 4'h0;
    mem_addr_d   = '0;
    mem_wdata_d  = 32'd0;
    task_start_d = (state_nxt == START);
    busy_d       = (state_nxt == START) || (state_nxt == BUSY);
    case (state_nxt)
      INIT_EN: begin
        if (init_step_nxt) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 4'hF;
          mem_addr_d  = A_ENABLED_TASKS;
          mem_wdata_d = {16'h0000, ENABLED_MASK};
        end
      end
      INIT_RDY: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 4'hF;
        mem_addr_d  = init_step_nxt ? A_PL_READY : A_TV_OUT_READY;
        mem_wdata_d = init_step_nxt ? 32'd1 : 32'd0;
      end
      RD_FLAG: begin
        mem_en_d   = 1'b1;
        mem_addr_d = A_TV_IN_READY;
      end
      RD_TASK: begin
        mem_en_d   = 1'b1;
        mem_addr_d = A_CURRENT_TASK;
      end
      CLR_FLAG: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 4'hF;
        mem_addr_d  = A_TV_IN_READY;
        mem_wdata_d = 32'd0;
      end
      DONE_WR: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 4'hF;
        mem_addr_d  = A_TV_OUT_READY;
        mem_wdata_d = 32'd1;
      end
      default: ;
    endcase
  end

  // Output registers; task_id holds its value until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_we     <= 4'h0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      task_start <= 1'b0;
      task_id    <= 4'd0;
      busy       <= 1'b0;
    end else begin
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      task_start <= task_start_d;
      busy       <= busy_d;
      if (task_start_d) task_id <= task_num;
    end
  end

`ifdef TASK_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;

  // Expires on the TIMEOUT_CYCLES-th BUSY cycle unless the task finishes then
  assign wd_expired = (state == BUSY) && !task_done &&
                      (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter over BUSY cycles and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == BUSY) ? wd_cnt + 1'b1 : '0;
      if (wd_expired) err_timeout <= 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
